// File: rtl/uart_sram_loader.sv
// Streams byte pairs from a UART receiver into consecutive SRAM words.
// High byte first; one SRAM write strobe per assembled 16-bit word.
module uart_sram_loader #(
    parameter logic [17:0] START_ADDR = 18'd0,
    parameter logic [18:0] NUM_WORDS  = 19'd153600
) (
    input  logic        Clock_50,
    input  logic        Resetn,
    input  logic        Start,
    input  logic [7:0]  RX_data,
    input  logic        Empty,
    input  logic        Overrun,
    input  logic        Frame_error,
    output logic        Receive_enable,
    output logic        Unload_data,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Done,
    output logic        Error
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HI,
        UNLOAD_HI,
        WAIT_LO,
        UNLOAD_LO,
        WRITE,
        DONE
    } state_t;

    localparam logic [18:0] LAST_W   = NUM_WORDS - 19'd1;
    localparam logic [17:0] LAST_CNT = LAST_W[17:0];

    state_t      state_q, state_d;
    logic [17:0] addr_q, addr_d;
    logic [17:0] cnt_q, cnt_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_n_q, we_n_d;
    logic        rx_en_q, rx_en_d;
    logic        unload_q, unload_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        active;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        active  = (state_q != IDLE) && (state_q != DONE);

        unique case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = WAIT_HI;
                    addr_d  = START_ADDR;
                    cnt_d   = 18'd0;
                    err_d   = 1'b0;
                end
            end
            WAIT_HI: begin
                if (!Empty) begin
                    hi_d    = RX_data;
                    state_d = UNLOAD_HI;
                end
            end
            UNLOAD_HI: state_d = WAIT_LO;
            WAIT_LO: begin
                if (!Empty) begin
                    lo_d    = RX_data;
                    state_d = UNLOAD_LO;
                end
            end
            UNLOAD_LO: begin
                wdata_d = {hi_q, lo_q};
                state_d = WRITE;
            end
            WRITE: begin
                // Last word parks the address; it never steps past the end.
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 18'd1;
                    cnt_d   = cnt_q + 18'd1;
                    state_d = WAIT_HI;
                end
            end
            default: state_d = IDLE;
        endcase

        if (active && (Overrun || Frame_error)) begin
            err_d = 1'b1;
        end

        // Outputs are decoded from the next state so each flop lines up
        // with the cycle its state is occupied.
        unload_d = (state_d == UNLOAD_HI) || (state_d == UNLOAD_LO);
        we_n_d   = (state_d != WRITE);
        rx_en_d  = (state_d != IDLE) && (state_d != DONE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            addr_q   <= START_ADDR;
            cnt_q    <= 18'd0;
            hi_q     <= 8'd0;
            lo_q     <= 8'd0;
            wdata_q  <= 16'd0;
            we_n_q   <= 1'b1;
            rx_en_q  <= 1'b0;
            unload_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            wdata_q  <= wdata_d;
            we_n_q   <= we_n_d;
            rx_en_q  <= rx_en_d;
            unload_q <= unload_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign Receive_enable  = rx_en_q;
    assign Unload_data     = unload_q;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign Done            = done_q;
    assign Error           = err_q;

endmodule
